// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating multiplexer: arbitration mode
// encodings and the index-width helper.
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational grant picker: rotates the request vector so the search starts
// at ptr, takes the lowest set bit, then rotates the result back.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            fixed,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [SELW-1:0] w_base;
  logic [N-1:0]    w_rot;
  logic [SELW-1:0] w_off;
  logic [SELW:0]   w_sum;

  // Fixed priority is just a rotation by zero.
  assign w_base = fixed ? '0 : ptr;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = i + int'(w_base);
      if (k >= N) k = k - N;
      w_rot[i] = req[k[SELW-1:0]];
    end
  end

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SELW'(i);
    end
  end

  // Modulo-N add so non-power-of-two N wraps correctly.
  assign w_sum   = {1'b0, w_base} + {1'b0, w_off};
  assign gnt_idx = (w_sum >= (SELW+1)'(N)) ? SELW'(w_sum - (SELW+1)'(N))
                                           : w_sum[SELW-1:0];
  assign any     = |req;

endmodule

// File: rtl/mux_arb_n.sv
// N-way arbitrating multiplexer with a registered output stage and
// valid/ready handshakes on every input channel and on the output.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int N         = 4,
  parameter  int FIXED_PRI = ARB_RR,
  localparam int SELW      = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_sel;
  logic [SELW-1:0]     r_ptr;

  logic [SELW-1:0]     w_gnt;
  logic                w_any;
  logic                w_load;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [SELW-1:0]     w_ptr_nxt;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .fixed   (FIXED_PRI == ARB_FIXED),
    .gnt_idx (w_gnt),
    .any     (w_any)
  );

  // Gating with rst_n keeps every in_ready low during the reset cycle.
  assign w_load = rst_n && (!r_out_valid || out_ready) && w_any;

  always_comb begin
    in_ready = '0;
    if (w_load) in_ready[w_gnt] = 1'b1;
  end

  assign w_gnt_data = in_data[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_ptr_nxt  = (w_gnt == SELW'(N - 1)) ? '0 : w_gnt + SELW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_sel   <= w_gnt;
      if (FIXED_PRI == ARB_RR) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: three instances (N=4 round-robin, N=4 fixed priority,
// N=3 round-robin) driven from a step table with a one-deep scoreboard.
module tb_mux_arb_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0]   v0, ir0;
  logic [127:0] d0;
  logic         ordy0, ov0;
  logic [31:0]  od0;
  logic [1:0]   os0;

  logic [3:0]   v1, ir1;
  logic [127:0] d1;
  logic         ordy1, ov1;
  logic [31:0]  od1;
  logic [1:0]   os1;

  logic [2:0]   v2, ir2;
  logic [95:0]  d2;
  logic         ordy2, ov2;
  logic [31:0]  od2;
  logic [1:0]   os2;

  mux_arb_n #(.WIDTH(32), .N(4), .FIXED_PRI(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0));

  mux_arb_n #(.WIDTH(32), .N(4), .FIXED_PRI(1)) u_fx4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1));

  mux_arb_n #(.WIDTH(32), .N(3), .FIXED_PRI(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy2));

  typedef struct {
    int         dut;
    logic [3:0] v;
    logic       r;
    logic [3:0] ir;
    logic       ov;
  } step_t;

  typedef struct {
    int          dut;
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [1:0]  last_sel  [3];
  logic [31:0] last_data [3];

  function automatic step_t mk(input int dut, input logic [3:0] v, input logic r,
                               input logic [3:0] ir, input logic ov);
    step_t s;
    s.dut = dut; s.v = v; s.r = r; s.ir = ir; s.ov = ov;
    return s;
  endfunction

  function automatic logic [31:0] word(input int dut, input int idx);
    logic [31:0] base;
    base = (dut == 0) ? 32'hA0 : (dut == 1) ? 32'hB0 : 32'hC0;
    return base + 32'(idx);
  endfunction

  function automatic int oh_idx(input logic [3:0] x);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (x[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] get_ir(input int dut);
    case (dut)
      0:       return ir0;
      1:       return ir1;
      default: return {1'b0, ir2};
    endcase
  endfunction

  function automatic logic get_ov(input int dut);
    case (dut)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [1:0] get_sel(input int dut);
    case (dut)
      0:       return os0;
      1:       return os1;
      default: return os2;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int dut);
    case (dut)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  task automatic drive(input int dut, input logic [3:0] v, input logic r);
    case (dut)
      0:       begin v0 = v;      ordy0 = r; end
      1:       begin v1 = v;      ordy1 = r; end
      default: begin v2 = v[2:0]; ordy2 = r; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input step_t s, input string tag);
    exp_t e;
    @(negedge clk);
    drive(s.dut, s.v, s.r);
    #1;
    chk({tag, " in_ready"}, 32'(get_ir(s.dut)), 32'(s.ir));
    if (s.ir != 4'b0) begin
      e.dut  = s.dut;
      e.sel  = 2'(oh_idx(s.ir));
      e.data = word(s.dut, oh_idx(s.ir));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(get_ov(s.dut)), 32'(s.ov));
    if (s.ir != 4'b0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      end else begin
        e = sb.pop_front();
        last_sel[e.dut]  = e.sel;
        last_data[e.dut] = e.data;
      end
    end
    chk({tag, " out_sel"},  32'(get_sel(s.dut)), 32'(last_sel[s.dut]));
    chk({tag, " out_data"}, get_data(s.dut), last_data[s.dut]);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s dut%0d in_ready", tag, d), 32'(get_ir(d)), 32'h0);
      chk($sformatf("%s dut%0d out_valid", tag, d), 32'(get_ov(d)), 32'h0);
      chk($sformatf("%s dut%0d out_data", tag, d), get_data(d), 32'h0);
      chk($sformatf("%s dut%0d out_sel", tag, d), 32'(get_sel(d)), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    d0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    d1 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    d2 = {32'hC2, 32'hC1, 32'hC0};
    for (int d = 0; d < 3; d++) begin
      last_sel[d]  = 2'b0;
      last_data[d] = 32'h0;
    end

    rst_n = 1'b0;
    v0 = 4'hF; v1 = 4'hF; v2 = 3'h7;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_state("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 4'h0; v1 = 4'h0; v2 = 3'h0;

    // Round-robin sweep, then backpressure, drain-and-load, idle drain.
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0001, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0010, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0100, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b1000, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0001, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0010, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b0, 4'b0000, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b0, 4'b0000, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b0, 4'b0000, 1'b1));
    steps.push_back(mk(0, 4'b1111, 1'b1, 4'b0100, 1'b1));
    steps.push_back(mk(0, 4'b0000, 1'b1, 4'b0000, 1'b0));
    steps.push_back(mk(0, 4'b0000, 1'b1, 4'b0000, 1'b0));
    steps.push_back(mk(0, 4'b0001, 1'b1, 4'b0001, 1'b1));
    steps.push_back(mk(0, 4'b0000, 1'b1, 4'b0000, 1'b0));
    // Fixed priority.
    steps.push_back(mk(1, 4'b1010, 1'b1, 4'b0010, 1'b1));
    steps.push_back(mk(1, 4'b1010, 1'b1, 4'b0010, 1'b1));
    steps.push_back(mk(1, 4'b1010, 1'b1, 4'b0010, 1'b1));
    steps.push_back(mk(1, 4'b1000, 1'b1, 4'b1000, 1'b1));
    steps.push_back(mk(1, 4'b1111, 1'b1, 4'b0001, 1'b1));
    steps.push_back(mk(1, 4'b1111, 1'b0, 4'b0000, 1'b1));
    steps.push_back(mk(1, 4'b0000, 1'b1, 4'b0000, 1'b0));
    // N=3 wrap from channel 2 back to 0.
    steps.push_back(mk(2, 4'b0100, 1'b1, 4'b0100, 1'b1));
    steps.push_back(mk(2, 4'b0101, 1'b1, 4'b0001, 1'b1));
    steps.push_back(mk(2, 4'b0101, 1'b1, 4'b0100, 1'b1));
    steps.push_back(mk(2, 4'b0000, 1'b1, 4'b0000, 1'b0));

    for (int i = 0; i < steps.size(); i++) begin
      apply(steps[i], $sformatf("step%0d", i));
    end

    // Reset while a word sits in the output register; ptr must restart at 0.
    apply(mk(0, 4'b0001, 1'b1, 4'b0001, 1'b1), "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    v0 = 4'hF;
    #1;
    chk("midrst in_ready", 32'(ir0), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst out_valid", 32'(ov0), 32'h0);
    chk("midrst out_data", od0, 32'h0);
    chk("midrst out_sel", 32'(os0), 32'h0);
    for (int d = 0; d < 3; d++) begin
      last_sel[d]  = 2'b0;
      last_data[d] = 32'h0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    v0 = 4'h0;
    apply(mk(0, 4'b1111, 1'b1, 4'b0001, 1'b1), "post_rst0");
    apply(mk(0, 4'b1111, 1'b1, 4'b0010, 1'b1), "post_rst1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
